arbitro_rr: RTL and testbench

- Round-robin arbiter/scheduler between the four class input FIFOs (word [11:10] class, [9:8] destination, [7:0] data) and the four destination output FIFOs.
- Each cycle it selects at most one eligible input, pops its head word, and pushes that word one cycle later into the output FIFO addressed by the word's destination field.
- Runs only while the FIFO configuration state machine reports the ACTIVE state.

---
 rtl/arbitro_rr_pkg.sv | 23 ++
 rtl/arbitro_rr_if.sv | 29 ++
 rtl/arbitro_rr_picker4.sv | 22 ++
 rtl/arbitro_rr.sv | 82 ++++++++
 tb/tb_arbitro_rr.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/arbitro_rr_pkg.sv
// Shared definitions for the round-robin class-to-destination arbiter.
// Word layout: [11:10] class, [9:8] destination, [7:0] data.
package arbitro_rr_pkg;

    localparam int unsigned WORD_SIZE  = 12;
    localparam int unsigned CLASS_LSB  = 10;
    localparam int unsigned DEST_LSB   = 8;
    localparam int unsigned NUM_PORTS  = 4;

    // Code the FIFO configuration state machine uses for its ACTIVE state
    localparam logic [1:0] CFG_ST_ACTIVE = 2'b11;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'b00,
        ST_ARB   = 2'b01,
        ST_DRAIN = 2'b10
    } arb_state_t;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/arbitro_rr_if.sv
// Arbiter bus: input FIFO heads/flags, output FIFO flags, pop/push handshake.
interface arbitro_rr_if #(
    parameter int unsigned WORD_SIZE = arbitro_rr_pkg::WORD_SIZE
);
    logic                 active;
    logic [3:0]           fifos_empty;
    logic [WORD_SIZE-1:0] fifo_data0;
    logic [WORD_SIZE-1:0] fifo_data1;
    logic [WORD_SIZE-1:0] fifo_data2;
    logic [WORD_SIZE-1:0] fifo_data3;
    logic [3:0]           out_almost_full;
    logic [3:0]           pop;
    logic [3:0]           push;
    logic [WORD_SIZE-1:0] data_out;
    logic [1:0]           grant_id;
    logic                 arb_idle;

    modport slave (
        input  active, fifos_empty, fifo_data0, fifo_data1, fifo_data2, fifo_data3,
               out_almost_full,
        output pop, push, data_out, grant_id, arb_idle
    );

    modport master (
        output active, fifos_empty, fifo_data0, fifo_data1, fifo_data2, fifo_data3,
               out_almost_full,
        input  pop, push, data_out, grant_id, arb_idle
    );
endinterface

// File: rtl/arbitro_rr_picker4.sv
// Combinational 4-way round-robin picker: first eligible index after 'last'.
module rr_picker4 (
    input  logic [3:0] eligible,
    input  logic [1:0] last,
    output logic       grant_valid,
    output logic [1:0] grant_idx
);
    logic [1:0] idx;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = last;
        idx         = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end
endmodule

// File: rtl/arbitro_rr.sv
// Round-robin scheduler from four class FIFOs to four destination FIFOs.
// Pops combinationally in ARB, pushes the popped word one cycle later.
module arbitro_rr
    import arbitro_rr_pkg::*;
#(
    parameter int unsigned WORD_SIZE = arbitro_rr_pkg::WORD_SIZE,
    parameter int unsigned DEST_LSB  = arbitro_rr_pkg::DEST_LSB
) (
    input  logic          clk,
    input  logic          reset,
    arbitro_rr_if.slave   bus
);
    arb_state_t           state;
    logic [1:0]           last;
    logic [3:0]           push_q;
    logic [WORD_SIZE-1:0] data_q;
    logic [1:0]           grant_q;

    logic [WORD_SIZE-1:0] words [4];
    logic [3:0]           eligible;
    logic                 grant_valid;
    logic [1:0]           grant_idx;
    logic                 do_grant;
    logic [WORD_SIZE-1:0] sel_word;
    logic [1:0]           sel_dest;

    assign words[0] = bus.fifo_data0;
    assign words[1] = bus.fifo_data1;
    assign words[2] = bus.fifo_data2;
    assign words[3] = bus.fifo_data3;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            eligible[i] = !bus.fifos_empty[i] &&
                          !bus.out_almost_full[words[i][DEST_LSB +: 2]];
        end
    end

    rr_picker4 u_picker (
        .eligible    (eligible),
        .last        (last),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Gating on the live 'active' keeps a request that coincides with ACTIVE
    // going away from being popped.
    assign do_grant = reset && (state == ST_ARB) && bus.active && grant_valid;
    assign sel_word = words[grant_idx];
    assign sel_dest = sel_word[DEST_LSB +: 2];

    assign bus.pop      = do_grant ? onehot4(grant_idx) : '0;
    assign bus.push     = push_q;
    assign bus.data_out = data_q;
    assign bus.grant_id = grant_q;
    assign bus.arb_idle = !reset ||
                          (((state != ST_ARB) || !(|eligible)) && !(|push_q));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_WAIT;
            last    <= 2'd3;
            push_q  <= '0;
            data_q  <= '0;
            grant_q <= '0;
        end else begin
            push_q <= do_grant ? onehot4(sel_dest) : '0;
            if (do_grant) begin
                data_q  <= sel_word;
                grant_q <= grant_idx;
                last    <= grant_idx;
            end
            unique case (state)
                ST_WAIT:  if (bus.active) state <= ST_ARB;
                ST_ARB:   if (!bus.active) state <= ST_DRAIN;
                ST_DRAIN: state <= ST_WAIT;
                default:  state <= ST_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_arbitro_rr.sv
// Directed bench for arbitro_rr with hand-computed expectations.
module tb_arbitro_rr;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [11:0] dw [4];

    arbitro_rr_if #(.WORD_SIZE(12)) bus ();

    arbitro_rr #(.WORD_SIZE(12), .DEST_LSB(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        dw[0] = 12'h011;
        dw[1] = 12'h422;
        dw[2] = 12'h833;
        dw[3] = 12'hC44;
        reset               = 1'b0;
        bus.active          = 1'b1;
        bus.fifos_empty     = 4'b0000;
        bus.out_almost_full = 4'b0000;
        bus.fifo_data0      = dw[0];
        bus.fifo_data1      = dw[1];
        bus.fifo_data2      = dw[2];
        bus.fifo_data3      = dw[3];

        // Reset held three cycles with everything requesting
        for (int r = 0; r < 3; r++) begin
            tick();
            chk("rst_pop", bus.pop, 4'b0000);
            chk("rst_push", bus.push, 4'b0000);
            chk("rst_data", bus.data_out, 12'h000);
            chk("rst_gid", bus.grant_id, 2'd0);
            chk("rst_idle", bus.arb_idle, 1'b1);
        end

        reset = 1'b1;
        #1;
        chk("wait_pop", bus.pop, 4'b0000);
        tick();
        chk("first_pop", bus.pop, 4'b0001);
        chk("first_push", bus.push, 4'b0000);
        chk("arb_busy", bus.arb_idle, 1'b0);

        // Full rotation, all destinations 0
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rot_push", bus.push, 4'b0001);
            chk("rot_data", bus.data_out, dw[k]);
            chk("rot_gid", bus.grant_id, k);
            chk("rot_pop", bus.pop, 4'b0001 << ((k + 1) % 4));
        end

        // Single requester, input 1, destination 2
        bus.fifos_empty = 4'b1101;
        bus.fifo_data1  = 12'h2A5;
        #1;
        chk("single_pop", bus.pop, 4'b0010);
        tick();
        bus.fifos_empty = 4'b1111;
        #1;
        chk("single_push", bus.push, 4'b0100);
        chk("single_data", bus.data_out, 12'h2A5);
        chk("single_gid", bus.grant_id, 2'd1);
        chk("single_nopop", bus.pop, 4'b0000);
        chk("single_idle0", bus.arb_idle, 1'b0);
        tick();
        chk("empty_push", bus.push, 4'b0000);
        chk("empty_idle", bus.arb_idle, 1'b1);

        // Input 0 blocked by almost-full on destination 3
        bus.fifos_empty     = 4'b1010;
        bus.fifo_data0      = 12'h311;
        bus.fifo_data2      = 12'h833;
        bus.out_almost_full = 4'b1000;
        #1;
        chk("af_pop0", bus.pop, 4'b0100);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("af_push", bus.push, 4'b0001);
            chk("af_data", bus.data_out, 12'h833);
            chk("af_gid", bus.grant_id, 2'd2);
            chk("af_pop", bus.pop, 4'b0100);
        end
        bus.out_almost_full = 4'b0000;
        #1;
        chk("afclr_pop", bus.pop, 4'b0001);
        tick();
        chk("alt_push0", bus.push, 4'b1000);
        chk("alt_data0", bus.data_out, 12'h311);
        chk("alt_gid0", bus.grant_id, 2'd0);
        chk("alt_pop2", bus.pop, 4'b0100);
        tick();
        chk("alt_push2", bus.push, 4'b0001);
        chk("alt_data2", bus.data_out, 12'h833);
        chk("alt_gid2", bus.grant_id, 2'd2);
        chk("alt_pop0", bus.pop, 4'b0001);

        // active drops the cycle after a grant
        tick();
        chk("drop_push", bus.push, 4'b1000);
        chk("drop_data", bus.data_out, 12'h311);
        bus.active = 1'b0;
        #1;
        chk("drop_nopop", bus.pop, 4'b0000);
        chk("drop_idle0", bus.arb_idle, 1'b0);
        tick();
        chk("drain_push", bus.push, 4'b0000);
        chk("drain_pop", bus.pop, 4'b0000);
        chk("drain_idle", bus.arb_idle, 1'b1);
        tick();
        chk("wait_idle", bus.arb_idle, 1'b1);
        chk("wait_push", bus.push, 4'b0000);
        bus.active = 1'b1;
        #1;
        chk("wait_nopop", bus.pop, 4'b0000);
        tick();
        chk("rearb_pop", bus.pop, 4'b0100);
        chk("rearb_idle", bus.arb_idle, 1'b0);

        // Reset the cycle after a pop
        tick();
        chk("prerst_push", bus.push, 4'b0001);
        chk("prerst_pop", bus.pop, 4'b0001);
        reset = 1'b0;
        #1;
        chk("rstmid_pop", bus.pop, 4'b0000);
        tick();
        chk("rstmid_push", bus.push, 4'b0000);
        chk("rstmid_data", bus.data_out, 12'h000);
        chk("rstmid_gid", bus.grant_id, 2'd0);
        chk("rstmid_idle", bus.arb_idle, 1'b1);
        reset = 1'b1;
        #1;
        chk("postrst_wait", bus.pop, 4'b0000);
        tick();
        chk("postrst_pop", bus.pop, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
